stage_f: RTL and testbench

- Fetch stage; sits directly upstream of decode and feeds it PCF, PCPlus4F and RDD.
- Owns the PC register and the next-PC select:
  - sequential PC+4;
  - RISC-V redirect from execute (PCSrcE/PCTargetE);
  - ARM redirect from writeback (PCSrcW/ResultW).
- Talks to instruction memory over a req/gnt/rvalid handshake, buffers one returned instruction, and requests a decode bubble while a fetch is outstanding.

---
 rtl/stage_f_pkg.sv | 14 +
 rtl/stage_f_if.sv | 21 ++
 rtl/stage_f_pc_next_sel.sv | 17 +
 rtl/stage_f.sv | 121 ++++++++++++
 tb/tb_stage_f.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_f_pkg.sv
// Shared pipeline definitions for fetch and decode:
// fetch FSM states, the NOP encoding and the default reset PC.
package stage_f_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DISCARD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/stage_f_if.sv
// Instruction-memory req/gnt/rvalid bus.
// master: fetch side (drives ImemReq/ImemAddr); slave: memory side.
interface stage_f_if;

  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemGnt, ImemRValid, ImemRData
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemGnt, ImemRValid, ImemRData
  );

endinterface

// File: rtl/stage_f_pc_next_sel.sv
// Redirect/target select: ARM redirects come from writeback,
// RISC-V redirects from execute. Ports: arm, PCSrcE/PCTargetE,
// PCSrcW/ResultW in; o_redir/o_target out.
module pc_next_sel (
  input  logic        arm,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        o_redir,
  output logic [31:0] o_target
);

  assign o_redir  = arm ? PCSrcW  : PCSrcE;
  assign o_target = arm ? ResultW : PCTargetE;

endmodule

// File: rtl/stage_f.sv
// Fetch stage: PC register, next-PC select, one-deep imem buffer.
// Ports: clk/rst, arm, stall/flush, redirects, imem bus, PCF/PCPlus4F/RDD/FetchBusyF.
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arm,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         PCSrcE,
  input  logic [31:0]  PCTargetE,
  input  logic         PCSrcW,
  input  logic [31:0]  ResultW,
  stage_f_if.master    imem,
  output logic [31:0]  PCF,
  output logic [31:0]  PCPlus4F,
  output logic [31:0]  RDD,
  output logic         FetchBusyF
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic        r_buf_vld;
  logic [31:0] r_rdd;

  logic        w_redir;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_gnt;
  logic        w_load;
  logic        w_handoff;

  pc_next_sel u_sel (
    .arm       (arm),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .PCSrcW    (PCSrcW),
    .ResultW   (ResultW),
    .o_redir   (w_redir),
    .o_target  (w_target)
  );

  assign w_pc_plus4 = r_pc + 32'd4;

  // A grant only matters while we could be asking; a grant that
  // lands together with a redirect still leaves a word in flight.
  assign w_gnt = imem.ImemGnt && (r_state == REQ) && !r_buf_vld;

  assign w_load = (r_state == WAIT) && imem.ImemRValid && !w_redir;

  assign w_handoff = !StallD && !FlushD && r_buf_vld
                  && !StallF && !w_redir;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      REQ: begin
        if (w_gnt)
          w_state_nxt = w_redir ? DISCARD : WAIT;
      end
      WAIT: begin
        if (imem.ImemRValid)
          w_state_nxt = REQ;
        else if (w_redir)
          w_state_nxt = DISCARD;
      end
      DISCARD: begin
        if (imem.ImemRValid)
          w_state_nxt = REQ;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= REQ;
      r_pc      <= RESET_PC;
      r_buf     <= NOP_INSTR;
      r_buf_vld <= 1'b0;
      r_rdd     <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;

      if (w_redir)
        r_pc <= w_target;
      else if (w_handoff)
        r_pc <= w_pc_plus4;

      if (w_redir || w_handoff)
        r_buf_vld <= 1'b0;
      else if (w_load)
        r_buf_vld <= 1'b1;

      if (w_load)
        r_buf <= imem.ImemRData;

      // Decode sees a bubble unless a word is actually handed off.
      if (!StallD)
        r_rdd <= w_handoff ? r_buf : NOP_INSTR;
    end
  end

  // Request is masked during reset so nothing leaks out early.
  assign imem.ImemReq  = !rst && (r_state == REQ)
                      && !r_buf_vld && !w_redir;
  assign imem.ImemAddr = r_pc;

  assign PCF        = r_pc;
  assign PCPlus4F   = w_pc_plus4;
  assign RDD        = r_rdd;
  assign FetchBusyF = !r_buf_vld;

endmodule

// File: tb/tb_stage_f.sv
// Directed bench for stage_f: per-cycle vector table,
// then latency, ARM-mode and reset-during-fetch sequences.
module tb_stage_f;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        StallF, StallD, FlushD;
  logic        PCSrcE, PCSrcW;
  logic [31:0] PCTargetE, ResultW;
  logic [31:0] PCF, PCPlus4F, RDD;
  logic        FetchBusyF;

  int checks = 0;
  int fails  = 0;

  stage_f_if imem ();

  stage_f dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .PCSrcW     (PCSrcW),
    .ResultW    (ResultW),
    .imem       (imem),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .RDD        (RDD),
    .FetchBusyF (FetchBusyF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  c;
    logic [31:0] t;
    logic        g;
    logic        v;
    logic [31:0] d;
    logic        rq;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        b;
  } vec_t;

  localparam logic [4:0] N   = 5'b00000;
  localparam logic [4:0] STD = 5'b10000;
  localparam logic [4:0] FLD = 5'b01000;
  localparam logic [4:0] STF = 5'b00100;
  localparam logic [4:0] PSE = 5'b00010;
  localparam logic [4:0] PSW = 5'b00001;

  localparam int NV = 34;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [4:0]  c,
    input logic [31:0] t,
    input logic        g,
    input logic        v,
    input logic [31:0] d,
    input logic        rq,
    input logic [31:0] pc,
    input logic [31:0] rd,
    input logic        b
  );
    vec_t x;
    x.c = c; x.t = t; x.g = g; x.v = v; x.d = d;
    x.rq = rq; x.pc = pc; x.rd = rd; x.b = b;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    StallF = 0; StallD = 0; FlushD = 0;
    PCSrcE = 0; PCSrcW = 0;
    PCTargetE = 0; ResultW = 0;
    imem.ImemGnt = 0; imem.ImemRValid = 0;
    imem.ImemRData = 0;
  endtask

  initial begin
    logic [31:0] p;
    int nreq;

    // row: ctl, tgt, gnt, rv, rdata | req, PCF, RDD, busy
    tbl[0]  = mk(N,   0,          1, 0, 0,          1, 0,          0,          1);
    tbl[1]  = mk(N,   0,          0, 1, 32'hA0B0C0D0, 0, 0,        0,          1);
    tbl[2]  = mk(N,   0,          0, 0, 0,          0, 0,          0,          0);
    tbl[3]  = mk(N,   0,          1, 0, 0,          1, 4,          32'hA0B0C0D0, 1);
    tbl[4]  = mk(PSE, 32'h100,    0, 0, 0,          0, 4,          0,          1);
    tbl[5]  = mk(N,   0,          0, 1, 32'hDEADBEEF, 0, 32'h100,  0,          1);
    tbl[6]  = mk(N,   0,          1, 0, 0,          1, 32'h100,    0,          1);
    tbl[7]  = mk(N,   0,          0, 1, 32'hCAFEF00D, 0, 32'h100,  0,          1);
    tbl[8]  = mk(N,   0,          0, 0, 0,          0, 32'h100,    0,          0);
    tbl[9]  = mk(STD, 0,          1, 0, 0,          1, 32'h104,    32'hCAFEF00D, 1);
    tbl[10] = mk(STD, 0,          0, 1, 32'h11223344, 0, 32'h104,  32'hCAFEF00D, 1);
    tbl[11] = mk(STD, 0,          0, 0, 0,          0, 32'h104,    32'hCAFEF00D, 0);
    tbl[12] = mk(STD, 0,          0, 0, 0,          0, 32'h104,    32'hCAFEF00D, 0);
    tbl[13] = mk(STD, 0,          0, 0, 0,          0, 32'h104,    32'hCAFEF00D, 0);
    tbl[14] = mk(N,   0,          0, 0, 0,          0, 32'h104,    32'hCAFEF00D, 0);
    tbl[15] = mk(N,   0,          0, 0, 0,          1, 32'h108,    32'h11223344, 1);
    tbl[16] = mk(N,   0,          1, 0, 0,          1, 32'h108,    0,          1);
    tbl[17] = mk(N,   0,          0, 1, 32'h55667788, 0, 32'h108,  0,          1);
    tbl[18] = mk(STF, 0,          0, 0, 0,          0, 32'h108,    0,          0);
    tbl[19] = mk(FLD, 0,          0, 0, 0,          0, 32'h108,    0,          0);
    tbl[20] = mk(N,   0,          0, 0, 0,          0, 32'h108,    0,          0);
    tbl[21] = mk(N,   0,          0, 0, 0,          1, 32'h10C,    32'h55667788, 1);
    tbl[22] = mk(PSW, 32'hDEAD0000, 1, 0, 0,        1, 32'h10C,    0,          1);
    tbl[23] = mk(PSE, 32'h200,    0, 1, 32'hBADBAD01, 0, 32'h10C,  0,          1);
    tbl[24] = mk(PSE, 32'h300,    1, 0, 0,          0, 32'h200,    0,          1);
    tbl[25] = mk(N,   0,          0, 1, 32'hBADBAD02, 0, 32'h300,  0,          1);
    tbl[26] = mk(N,   0,          1, 0, 0,          1, 32'h300,    0,          1);
    tbl[27] = mk(N,   0,          0, 1, 32'h77777777, 0, 32'h300,  0,          1);
    tbl[28] = mk(N,   0,          0, 0, 0,          0, 32'h300,    0,          0);
    tbl[29] = mk(PSE, 32'hFFFFFFFC, 0, 0, 0,        0, 32'h304,    32'h77777777, 1);
    tbl[30] = mk(N,   0,          1, 0, 0,          1, 32'hFFFFFFFC, 0,        1);
    tbl[31] = mk(N,   0,          0, 1, 32'h12345678, 0, 32'hFFFFFFFC, 0,      1);
    tbl[32] = mk(N,   0,          0, 0, 0,          0, 32'hFFFFFFFC, 0,        0);
    tbl[33] = mk(N,   0,          0, 0, 0,          1, 0,          32'h12345678, 1);

    // Reset state, RISC-V mode
    rst = 1; arm = 0;
    idle_in();
    @(negedge clk);
    #1;
    chk("rst req", {31'd0, imem.ImemReq}, 0);
    chk("rst pcf", PCF, 0);
    chk("rst rdd", RDD, 0);
    chk("rst busy", {31'd0, FetchBusyF}, 1);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      StallD = tbl[i].c[4];
      FlushD = tbl[i].c[3];
      StallF = tbl[i].c[2];
      PCSrcE = tbl[i].c[1];
      PCSrcW = tbl[i].c[0];
      PCTargetE = tbl[i].t;
      ResultW   = tbl[i].t;
      imem.ImemGnt    = tbl[i].g;
      imem.ImemRValid = tbl[i].v;
      imem.ImemRData  = tbl[i].d;
      #1;
      chk($sformatf("v%0d req", i), {31'd0, imem.ImemReq}, {31'd0, tbl[i].rq});
      chk($sformatf("v%0d pcf", i), PCF, tbl[i].pc);
      chk($sformatf("v%0d addr", i), imem.ImemAddr, tbl[i].pc);
      chk($sformatf("v%0d pc4", i), PCPlus4F, tbl[i].pc + 32'd4);
      chk($sformatf("v%0d rdd", i), RDD, tbl[i].rd);
      chk($sformatf("v%0d busy", i), {31'd0, FetchBusyF}, {31'd0, tbl[i].b});
      @(negedge clk);
    end
    idle_in();

    // 4-cycle rvalid latency, two instructions
    p = 0;
    nreq = 0;
    for (int k = 0; k < 2; k++) begin
      imem.ImemGnt = 1;
      #1;
      chk("lat req", {31'd0, imem.ImemReq}, 1);
      chk("lat addr", imem.ImemAddr, p);
      nreq += int'(imem.ImemReq);
      @(negedge clk);
      imem.ImemGnt = 0;
      for (int w = 0; w < 3; w++) begin
        #1;
        chk("lat wreq", {31'd0, imem.ImemReq}, 0);
        chk("lat busy", {31'd0, FetchBusyF}, 1);
        chk("lat rdd", RDD, 0);
        chk("lat pcf", PCF, p);
        nreq += int'(imem.ImemReq);
        @(negedge clk);
      end
      imem.ImemRValid = 1;
      imem.ImemRData  = 32'hC0DE0000 + p;
      #1;
      nreq += int'(imem.ImemReq);
      chk("lat busy4", {31'd0, FetchBusyF}, 1);
      @(negedge clk);
      imem.ImemRValid = 0;
      #1;
      nreq += int'(imem.ImemReq);
      chk("lat rdy", {31'd0, FetchBusyF}, 0);
      chk("lat hpcf", PCF, p);
      @(negedge clk);
      #1;
      chk("lat word", RDD, 32'hC0DE0000 + p);
      chk("lat next", PCF, p + 32'd4);
      p += 4;
    end
    chk("lat nreq", nreq, 2);

    // ARM mode: reset with arm=1
    @(negedge clk);
    rst = 1; arm = 1;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    imem.ImemGnt = 1;
    PCSrcE = 1; PCTargetE = 32'h300;
    #1;
    chk("arm ign", {31'd0, imem.ImemReq}, 1);
    @(negedge clk);
    imem.ImemGnt = 0;
    PCSrcW = 1; ResultW = 32'h200;
    #1;
    chk("arm wreq", {31'd0, imem.ImemReq}, 0);
    @(negedge clk);
    PCSrcW = 0; PCSrcE = 0;
    imem.ImemRValid = 1; imem.ImemRData = 32'hBAD0BAD0;
    #1;
    chk("arm pcf", PCF, 32'h200);
    chk("arm dreq", {31'd0, imem.ImemReq}, 0);
    @(negedge clk);
    imem.ImemRValid = 0;
    imem.ImemGnt = 1;
    #1;
    chk("arm addr", imem.ImemAddr, 32'h200);
    chk("arm req", {31'd0, imem.ImemReq}, 1);
    @(negedge clk);
    imem.ImemGnt = 0;
    imem.ImemRValid = 1; imem.ImemRData = 32'hAAAA5555;
    @(negedge clk);
    imem.ImemRValid = 0;
    #1;
    chk("arm rdy", {31'd0, FetchBusyF}, 0);
    @(negedge clk);
    StallD = 1;
    imem.ImemGnt = 1;
    #1;
    chk("arm rdd", RDD, 32'hAAAA5555);
    chk("arm pc4", PCF, 32'h204);
    @(negedge clk);
    imem.ImemGnt = 0;

    // Async reset in the middle of WAIT
    #1;
    rst = 1;
    #1;
    chk("ar pcf", PCF, 0);
    chk("ar rdd", RDD, 0);
    chk("ar req", {31'd0, imem.ImemReq}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    StallD = 0;
    imem.ImemRValid = 1; imem.ImemRData = 32'h57A1E000;
    #1;
    chk("ar rreq", {31'd0, imem.ImemReq}, 1);
    chk("ar addr", imem.ImemAddr, 0);
    @(negedge clk);
    imem.ImemRValid = 0;
    imem.ImemGnt = 1;
    #1;
    chk("ar stale", RDD, 0);
    chk("ar sbusy", {31'd0, FetchBusyF}, 1);
    @(negedge clk);
    imem.ImemGnt = 0;
    imem.ImemRValid = 1; imem.ImemRData = 32'h600DF00D;
    @(negedge clk);
    imem.ImemRValid = 0;
    #1;
    chk("ar rdy", {31'd0, FetchBusyF}, 0);
    chk("ar rdd0", RDD, 0);
    @(negedge clk);
    #1;
    chk("ar word", RDD, 32'h600DF00D);
    chk("ar pcf4", PCF, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
